stream_demux: RTL
=================

STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, as the payload width in bits.
REQ-002 The block SHALL take parameter N, default 4, as the number of output channels; legal range 2..8.
REQ-003 The block SHALL have SEL_W = max(1, clog2(N)) as a derived localparam, not overridable.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 in_valid  input  1  upstream word present.
REQ-007 in_ready  output  1  block accepts the word this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 in_sel  input  SEL_W  destination channel index.
REQ-010 out_valid  output  N  per-channel word present; bit k maps to channel k.
REQ-011 out_ready  input  N  per-channel downstream accept.
REQ-012 out_data  output  N*WIDTH  per-channel payload; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-013 drop_count  output  8  count of words dropped for out-of-range in_sel.

Function
REQ-014 The block SHALL treat a transfer as occurring on a port when valid and ready are both high at a rising clk.
REQ-015 Each channel SHALL hold a one-entry slot with states EMPTY and FULL; out_valid[k] SHALL be 1 exactly when slot k is FULL.
REQ-016 Slot transitions: EMPTY->FULL on input transfer to k; FULL->EMPTY on output transfer with no refill; FULL->FULL with new data on simultaneous output transfer and input transfer to k.
REQ-017 in_ready SHALL be combinational: 1 if in_sel>=N, else 1 if slot[in_sel] is EMPTY or out_ready[in_sel] is high.
REQ-018 in_ready SHALL NOT depend on in_valid, and no out_valid SHALL depend combinationally on out_ready.
REQ-019 Latency SHALL be exactly one cycle: a word accepted at edge t appears on out_valid/out_data at channel in_sel immediately after edge t.
REQ-020 A full slot with out_ready high SHALL sustain one word per cycle throughput on that channel.
REQ-021 out_data[k] SHALL hold stable while slot k is FULL and out_ready[k] is low.
REQ-022 A blocked channel SHALL NOT affect in_ready for words addressed to other channels.
REQ-023 On transfer with in_sel>=N, the block SHALL discard the word and increment drop_count, saturating at 255.
REQ-024 When N is a power of two, drop_count SHALL remain 0.
REQ-025 Slot k SHALL load only on an input transfer with in_sel==k; other slots remain unchanged.

Reset
REQ-026 While rst is high at a clk edge, all slots SHALL become EMPTY, out_valid SHALL be 0 and drop_count SHALL be 0.
REQ-027 out_data SHALL reset to 0.
REQ-028 Reset SHALL take priority over any simultaneous transfer, and words in flight SHALL be lost without a drop count.
REQ-029 While rst is high, in_ready SHALL be driven 0.

Structure
REQ-030 Package stream_demux_pkg SHALL hold slot_state_t (EMPTY, FULL) and default constants for WIDTH and N.
REQ-031 Sub-module demux_slot SHALL implement the one-entry slot: load, valid/ready, and data register.
REQ-032 stream_demux SHALL instantiate N copies of demux_slot and hold the routing and drop logic.

Verification
REQ-033 Reset then idle: after rst, out_valid==4'b0000, drop_count==0, and in_ready==1 with out_ready=0.
REQ-034 Route: send 8'hA5 with sel=2 and out_ready=4'b1111 -> next cycle out_valid==4'b0100 and data[2]==8'hA5; it clears the cycle after.
REQ-035 Backpressure: hold out_ready[1]=0 and send 8'h11 then 8'h22 to sel=1.
  - Expected: the second word stalls with in_ready==0 and 8'h11 holds.
  - Raising out_ready[1] delivers 8'h11 then 8'h22 in order.
REQ-036 Isolation: with slot 1 stalled FULL, send 8'h33 to sel=3 -> accepted immediately, and out_valid==4'b1010.
REQ-037 Throughput: stream 16 words to sel=0 with out_ready[0]=1 -> one word per cycle, no bubble, and order preserved.
REQ-038 Drop and reset: with N=3, send 300 words with sel=3 -> drop_count saturates at 255; a mid-stream rst clears the slots and the count.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and default sizing for the stream demultiplexer.
// Every file in the demux slice imports this package.
package stream_demux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_N     = 4;
    localparam int DROP_MAX      = 255;

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: holds a single word for one channel.
// A refill on the same cycle as a drain keeps the slot full.
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic             can_load,
    output logic [WIDTH-1:0] data
);

    slot_state_t state, next_state;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            EMPTY: if (load) next_state = FULL;
            FULL:  if (!load && ready) next_state = EMPTY;
        endcase
    end

    // The data register only moves on a load, so it holds while the slot stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_data;
        end
    end

    assign valid    = (state == FULL);
    assign can_load = (state == EMPTY) || ready;
    assign data     = data_q;

endmodule

// File: rtl/stream_demux.sv
// Routes one input stream to N single-entry output channels by in_sel.
// Words addressed past the last channel are accepted and counted as drops.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int N     = DEFAULT_N,
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]   in_sel,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [7:0]         drop_count
);

    logic [N-1:0] sel_match;
    logic [N-1:0] slot_can_load;
    logic [N-1:0] slot_load;
    logic         in_range;
    logic         in_fire;

    // One-hot decode avoids indexing the slot arrays with an out-of-range select.
    always_comb begin
        sel_match = '0;
        for (int k = 0; k < N; k++) begin
            sel_match[k] = (in_sel == SEL_W'(k));
        end
    end

    assign in_range  = |sel_match;
    assign in_ready  = !rst && (!in_range || |(sel_match & slot_can_load));
    assign in_fire   = in_valid && in_ready;
    assign slot_load = sel_match & {N{in_fire}};

    for (genvar k = 0; k < N; k++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (slot_load[k]),
            .load_data(in_data),
            .ready    (out_ready[k]),
            .valid    (out_valid[k]),
            .can_load (slot_can_load[k]),
            .data     (out_data[k*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (in_fire && !in_range && (drop_count != 8'(DROP_MAX))) begin
            drop_count <= drop_count + 8'd1;
        end
    end

endmodule
